// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared definitions for the memory-access pipeline stage: bus widths,
// access op codes, FSM state encodings, zero constants, and small helper
// functions for classifying ops, picking byte lanes and replicating store data.
package mem_access_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int SEL_W  = 4;
  localparam int OP_W   = 4;
  localparam int ST_W   = 2;

  // Access codes; 9-15 are unused and behave as NONE.
  localparam logic [OP_W-1:0] OP_NONE = 4'd0;
  localparam logic [OP_W-1:0] OP_LB   = 4'd1;
  localparam logic [OP_W-1:0] OP_LBU  = 4'd2;
  localparam logic [OP_W-1:0] OP_LH   = 4'd3;
  localparam logic [OP_W-1:0] OP_LHU  = 4'd4;
  localparam logic [OP_W-1:0] OP_LW   = 4'd5;
  localparam logic [OP_W-1:0] OP_SB   = 4'd6;
  localparam logic [OP_W-1:0] OP_SH   = 4'd7;
  localparam logic [OP_W-1:0] OP_SW   = 4'd8;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_BUSY = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE = 2'd2;

  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  localparam logic [REG_W-1:0]  ZERO_REG  = '0;
  localparam logic [SEL_W-1:0]  ZERO_SEL  = '0;

  function automatic logic is_load(input logic [OP_W-1:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
           (op == OP_LHU) || (op == OP_LW);
  endfunction

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [OP_W-1:0] op,
                                         input logic [1:0]      a);
    case (op)
      OP_LH, OP_LHU, OP_SH: return a[0];
      OP_LW, OP_SW:         return (a != 2'b00);
      default:              return 1'b0;
    endcase
  endfunction

  // Big-endian lanes: byte address 0 lives in bus_sel[3] / data[31:24].
  function automatic logic [SEL_W-1:0] lane_sel(input logic [OP_W-1:0] op,
                                                input logic [1:0]      a);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'b1000 >> a;
      OP_LH, OP_LHU, OP_SH: return a[1] ? 4'b0011 : 4'b1100;
      OP_LW, OP_SW:         return 4'b1111;
      default:              return ZERO_SEL;
    endcase
  endfunction

  // Replicating the datum means any selected lane already carries it.
  function automatic logic [DATA_W-1:0] store_data(input logic [OP_W-1:0]   op,
                                                   input logic [DATA_W-1:0] d);
    case (op)
      OP_SB:   return {4{d[7:0]}};
      OP_SH:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// load_align
// Combinational load lane selection with sign/zero extension.
// Ports:
//   rdata  - 32-bit word returned by the bus
//   addr   - low two bits of the byte address
//   op     - access code (only load codes produce a non-zero result)
//   result - extended load value
module load_align
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  lane_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Lane gi holds byte address gi (big-endian).
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_byte[gi] = rdata[DATA_W-1-8*gi -: 8];
  end

  assign sel_byte = lane_byte[addr];
  assign sel_half = addr[1] ? rdata[15:0] : rdata[31:16];

  always_comb begin
    result = ZERO_WORD;
    case (op)
      OP_LB:   result = {{24{sel_byte[7]}}, sel_byte};
      OP_LBU:  result = {24'd0, sel_byte};
      OP_LH:   result = {{16{sel_half[15]}}, sel_half};
      OP_LHU:  result = {16'd0, sel_half};
      OP_LW:   result = rdata;
      default: result = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access
// MEM pipeline stage: passes non-memory results straight through, and runs
// loads/stores over a simple req/ack bus while stalling the pipeline.
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   mem_wdata/mem_waddr/mem_we     - result/store data, dest reg, write enable
//   mem_op, mem_addr               - access code and byte address
//   wb_wdata/wb_waddr/wb_we        - toward the MEM/WB register
//   bus_req/we/addr/sel/wdata      - bus request side
//   bus_rdata, bus_ack             - bus response side
//   stallreq                       - pipeline stall while an access is open
//   exc_align                      - one-cycle misalignment pulse
module mem_access
  import mem_access_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [REG_W-1:0]  mem_waddr,
  input  logic              mem_we,
  input  logic [OP_W-1:0]   mem_op,
  input  logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic [REG_W-1:0]  wb_waddr,
  output logic              wb_we,
  output logic              bus_req,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_addr,
  output logic [SEL_W-1:0]  bus_sel,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              stallreq,
  output logic              exc_align
);

  logic [ST_W-1:0]   state_reg, state_next;

  // Request captured on entry to BUSY so the bus stays stable regardless
  // of what the stalled pipeline presents meanwhile.
  logic [OP_W-1:0]   lat_op_reg;
  logic [DATA_W-1:0] lat_addr_reg;
  logic [DATA_W-1:0] lat_wdata_reg;
  logic [REG_W-1:0]  lat_waddr_reg;
  logic              lat_we_reg;

  logic [DATA_W-1:0] hold_wdata_reg;
  logic [REG_W-1:0]  hold_waddr_reg;
  logic              hold_we_reg;

  logic              st_idle, st_busy, st_done;
  logic [OP_W-1:0]   cur_op;
  logic [DATA_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [REG_W-1:0]  cur_waddr;
  logic              cur_we;
  logic              access_op, misaligned, req;
  logic [DATA_W-1:0] load_result;

  assign st_idle = (state_reg == ST_IDLE);
  assign st_busy = (state_reg == ST_BUSY);
  assign st_done = (state_reg == ST_DONE);

  assign cur_op    = st_busy ? lat_op_reg    : mem_op;
  assign cur_addr  = st_busy ? lat_addr_reg  : mem_addr;
  assign cur_wdata = st_busy ? lat_wdata_reg : mem_wdata;
  assign cur_waddr = st_busy ? lat_waddr_reg : mem_waddr;
  assign cur_we    = st_busy ? lat_we_reg    : mem_we;

  assign access_op  = is_load(cur_op) || is_store(cur_op);
  assign misaligned = access_op && is_misaligned(cur_op, cur_addr[1:0]);
  // A bus_ack outside this window is ignored, and bus_rdata is only used
  // when it coincides with req.
  assign req        = st_busy || (st_idle && access_op && !misaligned);

  load_align u_load_align (
    .rdata  (bus_rdata),
    .addr   (cur_addr[1:0]),
    .op     (cur_op),
    .result (load_result)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (req) state_next = bus_ack ? ST_DONE : ST_BUSY;
      ST_BUSY: if (bus_ack) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      lat_op_reg     <= OP_NONE;
      lat_addr_reg   <= ZERO_WORD;
      lat_wdata_reg  <= ZERO_WORD;
      lat_waddr_reg  <= ZERO_REG;
      lat_we_reg     <= 1'b0;
      hold_wdata_reg <= ZERO_WORD;
      hold_waddr_reg <= ZERO_REG;
      hold_we_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (st_idle && req && !bus_ack) begin
        lat_op_reg    <= mem_op;
        lat_addr_reg  <= mem_addr;
        lat_wdata_reg <= mem_wdata;
        lat_waddr_reg <= mem_waddr;
        lat_we_reg    <= mem_we;
      end
      if (req && bus_ack) begin
        hold_wdata_reg <= is_load(cur_op) ? load_result : cur_wdata;
        hold_waddr_reg <= cur_waddr;
        // Stores never write the register file.
        hold_we_reg    <= is_load(cur_op) && cur_we;
      end
    end
  end

  // Reset forces every output low regardless of state or inputs.
  always_comb begin
    wb_wdata  = ZERO_WORD;
    wb_waddr  = ZERO_REG;
    wb_we     = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = ZERO_WORD;
    bus_sel   = ZERO_SEL;
    bus_wdata = ZERO_WORD;
    stallreq  = 1'b0;
    exc_align = 1'b0;
    if (!rst) begin
      if (req) begin
        bus_req  = 1'b1;
        bus_we   = is_store(cur_op);
        bus_addr = {cur_addr[DATA_W-1:2], 2'b00};
        bus_sel  = lane_sel(cur_op, cur_addr[1:0]);
        if (is_store(cur_op)) bus_wdata = store_data(cur_op, cur_wdata);
        stallreq = 1'b1;
      end
      exc_align = st_idle && misaligned;
      if (st_done) begin
        wb_wdata = hold_wdata_reg;
        wb_waddr = hold_waddr_reg;
        wb_we    = hold_we_reg;
      end else if (st_idle && !access_op) begin
        wb_wdata = mem_wdata;
        wb_waddr = mem_waddr;
        wb_we    = mem_we;
      end
    end
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports: clk input 1, system clock; rst input 1, reset. Reset rst is synchronous and active-high; clock is clk.
REQ-002 SHALL have ports: mem_wdata input 32, ALU result or store data from the EX/MEM register; mem_waddr input 5, destination register; mem_we input 1, register write enable.
REQ-003 SHALL have ports: mem_op input 4, access code; mem_addr input 32, effective byte address.
REQ-004 SHALL have ports: wb_wdata output 32, wb_waddr output 5, wb_we output 1, all toward the MEM/WB register.
REQ-005 SHALL have bus ports: bus_req output 1; bus_we output 1; bus_addr output 32; bus_sel output 4; bus_wdata output 32; bus_rdata input 32; bus_ack input 1.
REQ-006 SHALL have ports: stallreq output 1, pipeline stall request; exc_align output 1, misalignment pulse.

Function
REQ-007 SHALL decode mem_op: 0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; codes 9-15 SHALL be treated as NONE.
REQ-008 SHALL implement a state machine with states IDLE, BUSY and DONE.
REQ-009 In IDLE with NONE, SHALL pass wb_* = mem_* combinationally, with bus_req=0 and stallreq=0.
REQ-010 In IDLE with an aligned access, SHALL assert bus_req=1 and stallreq=1 in the same cycle.
- bus_addr = {mem_addr[31:2], 2'b00}.
- bus_we = 1 for stores only.
REQ-011 Byte lanes SHALL be big-endian.
- Byte access: addr[1:0] 00/01/10/11 gives bus_sel 1000/0100/0010/0001.
- Halfword: addr[1]=0 gives 1100; addr[1]=1 gives 0011.
- Word: 1111.
REQ-012 Store data SHALL be replicated across lanes:
- SB: bus_wdata = {4{byte}}.
- SH: bus_wdata = {2{half}}.
- SW: word unchanged.
REQ-013 On bus_ack in IDLE or BUSY, SHALL capture the result into a hold register and go to DONE; otherwise IDLE SHALL go to BUSY and BUSY SHALL hold.
REQ-014 In BUSY, bus_req, bus_addr, bus_sel, bus_we, bus_wdata and stallreq=1 SHALL be held stable until bus_ack.
REQ-015 Load result SHALL be the selected lane:
- LB and LH sign-extended.
- LBU and LHU zero-extended.
- LW the full word.
REQ-016 In DONE, SHALL drive wb_* from the hold register, with bus_req=0 and stallreq=0, then return to IDLE next cycle.
REQ-017 For loads, wb_we SHALL equal the latched mem_we. For stores, wb_we=0.
REQ-018 Latency:
- NONE: 0 cycles.
- Memory access with ack in cycle N after the request: result at DONE in cycle N+1.
- Minimum 1 stall cycle per access.
REQ-019 Misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]!=0):
- No bus access, bus_req=0.
- wb_we=0, stallreq=0, state remains IDLE.
- exc_align=1 for that cycle.
REQ-020 bus_ack while not requesting SHALL be ignored.
REQ-021 bus_rdata SHALL be sampled only in the cycle bus_ack=1.

Reset
REQ-022 While rst=1, all outputs SHALL be 0 (wb_wdata, wb_waddr, wb_we, bus_*, stallreq, exc_align), regardless of state or inputs.
REQ-023 At the first clk edge with rst=1, SHALL enter IDLE and clear the hold register.
REQ-024 Reset in BUSY SHALL abandon the access; a later bus_ack SHALL be ignored.

Structure
REQ-025 Op codes, state encodings, the zero constants and the 32/5/4-bit bus widths SHALL live in the shared defines file.
REQ-026 Lane selection plus sign/zero extension SHALL be a combinational sub-module load_align (inputs rdata, addr[1:0], op; output 32-bit result).

Verification
REQ-027 NONE pass-through: op=0, mem_wdata=0x12345678, waddr=5, we=1 -> same cycle wb_*=0x12345678/5/1, stallreq=0.
REQ-028 LB sign-extend with wait: op=1, addr=0x101, ack after 2 cycles, rdata=0x11F02233 -> stallreq high 3 cycles; DONE wb_wdata=0xFFFFFFF0; LBU gives 0x000000F0.
REQ-029 SH at addr=0x202, data=0x0000BEEF, ack same cycle -> bus_sel=0011, bus_wdata=0xBEEFBEEF, bus_we=1, wb_we=0.
REQ-030 LW misaligned at addr=0x3 -> bus_req=0, exc_align=1 one cycle, wb_we=0, stallreq=0.
REQ-031 Reset in BUSY: LW at 0x40, rst=1 before ack, then ack with 0xDEADBEEF -> all outputs 0; state IDLE; no DONE; 0xDEADBEEF never on wb_wdata.
